// File: rtl/mr_seq_pkg.sv
// rtl/mr_seq_pkg.sv - shared sizes, state type and helpers for the mixed-radix address sequencer
//
// Purpose : radix constants (3 x 5 = 15 addresses), digit/address widths,
//           FSM state enum and the end-of-frame digit test.
// Ports   : none (package).
package mr_seq_pkg;

  localparam int R3     = 3;
  localparam int R5     = 5;
  localparam int N_ADDR = R3 * R5;
  localparam int ADDR_W = 5;
  localparam int D3_W   = 2;
  localparam int D5_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Final digit pair of a frame: d3 = R3-1, d5 = R5-1 (address N_ADDR-1).
  function automatic logic is_last(input logic [D3_W-1:0] d3, input logic [D5_W-1:0] d5);
    return (d3 == D3_W'(R3 - 1)) && (d5 == D5_W'(R5 - 1));
  endfunction

endpackage

// File: rtl/mr_addr_map.sv
// rtl/mr_addr_map.sv - combinational digit-reversed address map (d3,d5) -> d5*3 + d3
//
// Purpose : converts the radix-3 / radix-5 digit pair into the output address.
//           Digit codes outside 0..2 / 0..4 map to address 0.
// Ports   : d3_i   [1:0] radix-3 digit
//           d5_i   [2:0] radix-5 digit
//           addr_o [4:0] mapped address, 0..14
import mr_seq_pkg::*;

module mr_addr_map (
  input  logic [D3_W-1:0]   d3_i,
  input  logic [D5_W-1:0]   d5_i,
  output logic [ADDR_W-1:0] addr_o
);

  always_comb begin
    addr_o = '0;
    if ((d3_i < D3_W'(R3)) && (d5_i < D5_W'(R5))) begin
      addr_o = ADDR_W'(d5_i) * ADDR_W'(R3) + ADDR_W'(d3_i);
    end
  end

endmodule

// File: rtl/mr_addr_seq.sv
// rtl/mr_addr_seq.sv - mixed-radix (3x5) digit-reversed address sequencer with valid/ready output
//
// Purpose : on start, emits the 15 addresses 0,3,6,9,12,1,4,...,14 with a
//           valid/ready handshake, flags the last one, then pulses done.
//           Optional macro MR_SEQ_CONT_EN adds the cont input: when high at
//           the last handshake the next frame follows with no gap.
// Ports   : clk        clock, rising edge
//           rst_n      asynchronous active-low reset
//           start      frame request, sampled in IDLE only
//           out_ready  downstream accepts current address
//           cont       continuous-frame request (MR_SEQ_CONT_EN only)
//           out_valid  out_addr / out_last valid
//           out_addr   [4:0] digit-reversed address
//           out_last   final address of a frame
//           busy       high while the frame is running
//           done       one-cycle pulse after the final handshake
import mr_seq_pkg::*;

module mr_addr_seq (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              out_ready,
`ifdef MR_SEQ_CONT_EN
  input  logic              cont,
`endif
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q;
  logic [D3_W-1:0]   d3_q, d3_d;
  logic [D5_W-1:0]   d5_q, d5_d;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] addr_d;
  logic              last_d;
  logic              hs;
  logic              cont_w;

`ifdef MR_SEQ_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif

  assign hs = out_valid_q & out_ready;

  // Next digit pair: counter with d5 as the fast (least significant) digit.
  always_comb begin
    d3_d = d3_q;
    d5_d = d5_q;
    case (state_q)
      ST_RUN: begin
        if (hs) begin
          if (d5_q == D5_W'(R5 - 1)) begin
            d5_d = '0;
            d3_d = (d3_q == D3_W'(R3 - 1)) ? '0 : d3_q + 1'b1;
          end else begin
            d5_d = d5_q + 1'b1;
          end
        end
      end
      default: begin
        d3_d = '0;
        d5_d = '0;
      end
    endcase
  end

  // The map is evaluated on the next digits so out_addr can be registered.
  mr_addr_map u_map (
    .d3_i   (d3_d),
    .d5_i   (d5_d),
    .addr_o (addr_d)
  );

  assign last_d = is_last(d3_d, d5_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      d3_q        <= '0;
      d5_q        <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= ST_RUN;
            d3_q        <= d3_d;
            d5_q        <= d5_d;
            out_valid_q <= 1'b1;
            out_addr_q  <= addr_d;
            out_last_q  <= last_d;
            busy_q      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (hs) begin
            d3_q <= d3_d;
            d5_q <= d5_d;
            if (is_last(d3_q, d5_q) && !cont_w) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              out_addr_q  <= '0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              // Continuous mode lands here too: digits wrapped to 0 -> addr 0.
              out_addr_q <= addr_d;
              out_last_q <= last_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          d3_q        <= '0;
          d5_q        <= '0;
          out_valid_q <= 1'b0;
          out_addr_q  <= '0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mr_addr_seq.sv
// tb/tb_mr_addr_seq.sv - self-checking bench for mr_addr_seq (vector table, corner sequences, random vs model)
`timescale 1ns/1ps
module tb_mr_addr_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       cont = 1'b0;
  logic       out_valid;
  logic [4:0] out_addr;
  logic       out_last;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  mr_addr_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .out_ready (out_ready),
`ifdef MR_SEQ_CONT_EN
    .cont      (cont),
`endif
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] a,
                         input logic l, input logic b, input logic d);
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".addr"},  {3'd0, out_addr},  {3'd0, a});
    chk({tag, ".last"},  {7'd0, out_last},  {7'd0, l});
    chk({tag, ".busy"},  {7'd0, busy},      {7'd0, b});
    chk({tag, ".done"},  {7'd0, done},      {7'd0, d});
  endtask

  // Frame position k -> address: k = d3*5 + d5, address = d5*3 + d3.
  function automatic int ord(input int k);
    return (k % 5) * 3 + (k / 5);
  endfunction

  // Transaction-level reference: active frame with position k, or a done beat.
  bit m_act, m_done;
  int m_k;

  task automatic model_reset();
    m_act = 0; m_done = 0; m_k = 0;
  endtask

  task automatic model_step(input bit s, input bit r, input bit c);
    if (m_done) begin
      m_done = 0;
    end else if (!m_act) begin
      if (s) begin m_act = 1; m_k = 0; end
    end else if (r) begin
      if (m_k == 14) begin
        if (c) m_k = 0;
        else begin m_act = 0; m_done = 1; end
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk_out(tag, m_act, m_act ? 5'(ord(m_k)) : 5'd0, m_act && (m_k == 14), m_act, m_done);
  endtask

  typedef struct {
    logic       s;
    logic       r;
    logic       v;
    logic [4:0] a;
    logic       l;
    logic       b;
    logic       d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic r, input logic v, input int a,
                              input logic l, input logic b, input logic d);
    vec_t t;
    t.s = s; t.r = r; t.v = v; t.a = 5'(a); t.l = l; t.b = b; t.d = d;
    return t;
  endfunction

  initial begin
    bit found;
    int gap;
    int cnt;
    bit c_en;
`ifdef MR_SEQ_CONT_EN
    c_en = 1;
`else
    c_en = 0;
`endif

    // Inputs apply at the next rising edge; expected outputs after that edge.
    tbl.push_back(mk(1, 0, 1,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1,  3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1,  6, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1,  6, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1,  6, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1,  6, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1,  9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 12, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1,  1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1,  4, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1,  7, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 10, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 13, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1,  2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1,  5, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1,  8, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 11, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 14, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0,  0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0,  0, 0, 0, 0));

    #2;
    chk_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: stall at 6, start during RUN at 4, single done pulse.
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].s;
      out_ready = tbl[i].r;
      @(negedge clk);
      chk_out($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].a, tbl[i].l, tbl[i].b, tbl[i].d);
    end

    // Asynchronous reset while out_addr = 10.
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_addr == 5'd10) found = 1;
      else @(negedge clk);
    end
    chk("rst.reach10", {7'd0, found}, 8'd1);
    #2 rst_n = 1'b0;
    #1 chk_out("rst.async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) cnt++;
    end
    chk("rst.quiet", 8'(cnt), 8'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_out("rst.restart", 1, 0, 0, 1, 0);

    // Drain that frame, then start held high: gap between frames is 2 cycles.
    start = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid && out_last) found = 1;
      else @(negedge clk);
    end
    chk("hold.reach_last", {7'd0, found}, 8'd1);
    gap = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
      else gap++;
    end
    chk("hold.gap", 8'(gap), 8'd2);
    chk("hold.addr0", {3'd0, out_addr}, 8'd0);
    start = 1'b0;
    for (int i = 0; i < 20 && (busy || done); i++) @(negedge clk);
    chk("hold.idle", {6'd0, busy, done}, 8'd0);

`ifdef MR_SEQ_CONT_EN
    // Continuous frames: wrap 14 -> 0 with no gap, then drop cont.
    cont = 1'b1; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 14; i++) @(negedge clk);
    chk_out("cont.last1", 1, 14, 1, 1, 0);
    @(negedge clk);
    chk_out("cont.wrap", 1, 0, 0, 1, 0);
    cont = 1'b0;
    for (int i = 0; i < 14; i++) @(negedge clk);
    chk_out("cont.last2", 1, 14, 1, 1, 0);
    @(negedge clk);
    chk_out("cont.done", 0, 0, 0, 0, 1);
    @(negedge clk);
`endif

    // Random stimulus against the reference model, from a clean reset.
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; cont = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 800; i++) begin
      model_check($sformatf("rnd[%0d]", i));
      start = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cont = c_en ? ($urandom_range(0, 1) == 1) : 1'b0;
      model_step(start, out_ready, cont);
      @(negedge clk);
    end
    model_check("rnd.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mr_addr_seq.md
MR_ADDR_SEQ -- requirements
Module: mr_addr_seq

Interface
REQ-001 Parameters: none; all sizes come from the shared package.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 start  in  1  frame request; sampled only in IDLE.
REQ-005 out_ready  in  1  downstream accepts current address.
REQ-006 cont  in  1  continuous-frame request; present only when MR_SEQ_CONT_EN is defined.
REQ-007 out_valid  out  1  out_addr/out_last valid.
REQ-008 out_addr  out  5  mixed-radix digit-reversed address, range 0..14.
REQ-009 out_last  out  1  marks final address of a frame.
REQ-010 busy  out  1  high in RUN.
REQ-011 done  out  1  one-cycle pulse after final handshake of a frame.

Function
REQ-012 Internal digits: d3 (2 bits, 0..2) and d5 (3 bits, 0..4); linear index n = d3*5 + d5, d5 least significant.
REQ-013 Address map: out_addr = d5*3 + d3; unused digit codes unreachable, and the map returns 0 for them.
REQ-014 Frame order: 0,3,6,9,12,1,4,7,10,13,2,5,8,11,14.
REQ-015 States: IDLE, RUN, DONE; encoding from package.
REQ-016 IDLE: start=1 -> RUN, d3=d5=0; out_valid=1 the following cycle with out_addr=0 (1-cycle latency).
REQ-017 RUN: handshake = out_valid & out_ready; on handshake d5 increments; d5 wraps 4->0 with d3 increment.
REQ-018 Without handshake, out_addr, out_last and out_valid hold unchanged (no retraction, no change while stalled).
REQ-019 out_last = 1 exactly when d3=2 and d5=4 (out_addr=14).
REQ-020 Handshake on last: with cont=0 -> DONE, out_valid=0; DONE -> IDLE unconditionally next cycle, done=1 only in DONE.
REQ-021 start in RUN or DONE is ignored, not queued; start held high in IDLE after DONE launches a new frame.
REQ-022 busy = 1 in RUN only; out_valid = 1 in RUN only.
REQ-023 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-024 rst_n low: state=IDLE, d3=d5=0, out_valid=0, out_addr=0, out_last=0, busy=0, done=0, regardless of state.
REQ-025 Reset mid-frame discards the frame; no done pulse; first frame after release needs a new start.

Configuration
REQ-026 Macro MR_SEQ_CONT_EN defined: cont port present; handshake on last with cont=1 -> stays RUN, digits wrap to 0, next beat out_addr=0, out_valid stays 1, no done pulse.
REQ-027 MR_SEQ_CONT_EN undefined: no cont port; behaviour identical to cont=0.

Structure
REQ-028 Package mr_seq_pkg: R3=3, R5=5, N_ADDR=15, ADDR_W=5, state enum type.
REQ-029 Sub-module mr_addr_map: combinational (d3,d5)->addr, instantiated once, shared with the datapath's index conversion.

Verification
REQ-030 start pulse, out_ready=1 always -> 15 beats in REQ-014 order on consecutive cycles, out_last on addr 14, done one cycle later, busy low after.
REQ-031 out_ready=0 for 3 cycles while out_addr=6 -> addr 6 held, valid held, next beat 9 after ready rises.
REQ-032 start pulsed while RUN at addr 4 -> sequence unaffected, exactly one done pulse.
REQ-033 rst_n low while out_addr=10 -> all outputs 0 asynchronously; no done; new start restarts at 0.
REQ-034 MR_SEQ_CONT_EN, cont=1 -> after addr 14 next beat is 0 with no gap; drop cont during second frame -> done after its addr 14.
REQ-035 start held high continuously, cont absent -> frames separated by exactly DONE+IDLE (2 cycles without valid).
